// File: rtl/alu_control_sequencer.sv
// Instruction-side sequencer for the 8-bit ALU: decodes one instruction per handshake,
// holds its ALU controls for the op latency, then pulses writeback/jump/branch for one cycle.
module alu_control_sequencer #(
  parameter int unsigned SIMPLE_CYCLES = 1,
  parameter int unsigned SHIFT_CYCLES  = 2,
  parameter int unsigned MUL_CYCLES    = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        ZERO,
  output logic [2:0]  ALU_SELECT,
  output logic        ALU_SLL,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  DEST_REG,
  output logic        WRITE_EN,
  output logic        JUMP,
  output logic        BRANCH_TAKEN,
  output logic        ILLEGAL,
  output logic        BUSY
);

  localparam int unsigned MAX_AB = (SIMPLE_CYCLES > SHIFT_CYCLES) ? SIMPLE_CYCLES : SHIFT_CYCLES;
  localparam int unsigned MAXC   = (MAX_AB > MUL_CYCLES) ? MAX_AB : MUL_CYCLES;
  localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic           accept;

  logic [2:0]     d_sel;
  logic           d_sll, d_imm, d_neg, d_wr, d_jump, d_beq, d_bne, d_legal;
  logic [CW-1:0]  d_lat;

  logic [2:0]     sel_q, dest_q;
  logic           sll_q, imm_q, neg_q, wr_q, jump_q, beq_q, bne_q;

  logic           unused_bits;
  assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:0]};

  assign accept = INSTR_VALID && (state == IDLE);

  always_comb begin
    d_sel   = '0;
    d_sll   = 1'b0;
    d_imm   = 1'b0;
    d_neg   = 1'b0;
    d_wr    = 1'b0;
    d_jump  = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_legal = 1'b1;
    d_lat   = CW'(SIMPLE_CYCLES - 1);
    case (INSTRUCTION[31:24])
      8'h00: begin d_imm = 1'b1; d_wr = 1'b1; end
      8'h01: d_wr = 1'b1;
      8'h02: begin d_sel = 3'b001; d_wr = 1'b1; end
      8'h03: begin d_sel = 3'b001; d_neg = 1'b1; d_wr = 1'b1; end
      8'h04: begin d_sel = 3'b010; d_wr = 1'b1; end
      8'h05: begin d_sel = 3'b011; d_wr = 1'b1; end
      8'h06: d_jump = 1'b1;
      8'h07: begin d_sel = 3'b001; d_neg = 1'b1; d_beq = 1'b1; end
      8'h08: begin d_sel = 3'b001; d_neg = 1'b1; d_bne = 1'b1; end
      8'h09: begin d_sel = 3'b100; d_wr = 1'b1; d_lat = CW'(MUL_CYCLES - 1); end
      8'h0A: begin d_sel = 3'b101; d_sll = 1'b1; d_imm = 1'b1; d_wr = 1'b1; d_lat = CW'(SHIFT_CYCLES - 1); end
      8'h0B: begin d_sel = 3'b101; d_imm = 1'b1; d_wr = 1'b1; d_lat = CW'(SHIFT_CYCLES - 1); end
      8'h0C: begin d_sel = 3'b110; d_imm = 1'b1; d_wr = 1'b1; d_lat = CW'(SHIFT_CYCLES - 1); end
      8'h0D: begin d_sel = 3'b111; d_imm = 1'b1; d_wr = 1'b1; d_lat = CW'(SHIFT_CYCLES - 1); end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = d_legal ? EXEC : ERR;
      EXEC:    if (cnt == '0) state_n = WB;
      WB:      state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Illegal opcodes leave the held controls untouched, so ERR shows the previous op's controls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt    <= '0;
      sel_q  <= '0;
      dest_q <= '0;
      sll_q  <= 1'b0;
      imm_q  <= 1'b0;
      neg_q  <= 1'b0;
      wr_q   <= 1'b0;
      jump_q <= 1'b0;
      beq_q  <= 1'b0;
      bne_q  <= 1'b0;
    end else if (accept && d_legal) begin
      cnt    <= d_lat;
      sel_q  <= d_sel;
      dest_q <= INSTRUCTION[18:16];
      sll_q  <= d_sll;
      imm_q  <= d_imm;
      neg_q  <= d_neg;
      wr_q   <= d_wr;
      jump_q <= d_jump;
      beq_q  <= d_beq;
      bne_q  <= d_bne;
    end else if (state == EXEC && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    INSTR_READY  = (state == IDLE) && RESET_N;
    BUSY         = !INSTR_READY;
    ALU_SELECT   = sel_q;
    ALU_SLL      = sll_q;
    IMM_SEL      = imm_q;
    NEG_SEL      = neg_q;
    DEST_REG     = dest_q;
    WRITE_EN     = (state == WB) && wr_q;
    JUMP         = (state == WB) && jump_q;
    BRANCH_TAKEN = (state == WB) && ((beq_q && ZERO) || (bne_q && !ZERO));
    ILLEGAL      = (state == ERR);
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed and random instructions checked cycle by cycle
// against an opcode table and latency model.
module tb_alu_control_sequencer;

  localparam int SIMPLE = 1;
  localparam int SHIFT  = 2;
  localparam int MUL    = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic        ZERO = 1'b0;
  logic [2:0]  ALU_SELECT;
  logic        ALU_SLL, IMM_SEL, NEG_SEL;
  logic [2:0]  DEST_REG;
  logic        WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL, BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  alu_control_sequencer #(.SIMPLE_CYCLES(SIMPLE), .SHIFT_CYCLES(SHIFT), .MUL_CYCLES(MUL)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ZERO(ZERO), .ALU_SELECT(ALU_SELECT), .ALU_SLL(ALU_SLL),
    .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .DEST_REG(DEST_REG), .WRITE_EN(WRITE_EN),
    .JUMP(JUMP), .BRANCH_TAKEN(BRANCH_TAKEN), .ILLEGAL(ILLEGAL), .BUSY(BUSY)
  );

  typedef struct {
    bit       legal;
    bit [2:0] sel;
    bit       sll, imm, neg, wr, jmp, beq, bne;
    int       lat;
  } exp_t;

  exp_t     cur;
  bit [2:0] cur_dest;

  function automatic exp_t model(input bit [7:0] op);
    exp_t e;
    e = '{default: 0};
    e.legal = (op <= 8'h0D);
    if (!e.legal) return e;
    e.jmp = (op == 8'h06);
    e.beq = (op == 8'h07);
    e.bne = (op == 8'h08);
    e.wr  = !(e.jmp || e.beq || e.bne);
    e.neg = (op == 8'h03) || e.beq || e.bne;
    e.imm = (op == 8'h00) || (op >= 8'h0A);
    e.sll = (op == 8'h0A);
    case (op)
      8'h02, 8'h03, 8'h07, 8'h08: e.sel = 3'd1;
      8'h04:                      e.sel = 3'd2;
      8'h05:                      e.sel = 3'd3;
      8'h09:                      e.sel = 3'd4;
      8'h0A, 8'h0B:               e.sel = 3'd5;
      8'h0C:                      e.sel = 3'd6;
      8'h0D:                      e.sel = 3'd7;
      default:                    e.sel = 3'd0;
    endcase
    e.lat = (op == 8'h09) ? MUL : (op >= 8'h0A) ? SHIFT : SIMPLE;
    return e;
  endfunction

  // Issues one instruction and checks every cycle until its WB/ERR cycle; zmode 0/1 fixed ZERO, 2 random.
  task automatic do_instr(input logic [31:0] instr, input int zmode, output int waited);
    exp_t e;
    bit   z, wb;
    int   ncyc;
    e = model(instr[31:24]);
    waited = 0;
    @(negedge CLK);
    while (INSTR_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (INSTR_READY !== 1'b1) $display("FAIL ready_wait instr=%h got=%b want=1", instr, INSTR_READY);
    else n_pass++;
    INSTRUCTION = instr;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = $urandom;
    if (e.legal) begin
      cur      = e;
      cur_dest = instr[18:16];
    end
    ncyc = e.legal ? e.lat + 1 : 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      ZERO = z;
      #1;
      wb = e.legal && (c == ncyc);
      n_checks++;
      if ({INSTR_READY, BUSY} !== 2'b01)
        $display("FAIL busy instr=%h cyc=%0d got ready/busy=%b want=01", instr, c, {INSTR_READY, BUSY});
      else n_pass++;
      n_checks++;
      if ({ALU_SELECT, ALU_SLL, IMM_SEL, NEG_SEL, DEST_REG} !== {cur.sel, cur.sll, cur.imm, cur.neg, cur_dest})
        $display("FAIL controls instr=%h cyc=%0d got sel/sll/imm/neg/dest=%b want=%b", instr, c,
                 {ALU_SELECT, ALU_SLL, IMM_SEL, NEG_SEL, DEST_REG},
                 {cur.sel, cur.sll, cur.imm, cur.neg, cur_dest});
      else n_pass++;
      n_checks++;
      if ({WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL} !==
          {wb & e.wr, wb & e.jmp, wb & ((e.beq & z) | (e.bne & !z)), !e.legal})
        $display("FAIL pulses instr=%h cyc=%0d zero=%b got we/j/br/ill=%b want=%b", instr, c, z,
                 {WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL},
                 {wb & e.wr, wb & e.jmp, wb & ((e.beq & z) | (e.bne & !z)), !e.legal});
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({ALU_SELECT, ALU_SLL, IMM_SEL, NEG_SEL, DEST_REG, WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL} !== '0)
      $display("FAIL reset_outputs got=%b want=0",
               {ALU_SELECT, ALU_SLL, IMM_SEL, NEG_SEL, DEST_REG, WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL});
    else n_pass++;
    RESET_N = 1'b1;
    #1;
    n_checks++;
    if ({INSTR_READY, BUSY} !== 2'b10) $display("FAIL reset_ready got=%b want=10", {INSTR_READY, BUSY});
    else n_pass++;
    cur = '{default: 0};
    cur_dest = '0;
  endtask

  task automatic test_reset_mid_mult();
    @(negedge CLK);
    INSTRUCTION = 32'h09010203;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ALU_SELECT !== 3'b100) $display("FAIL mid_mult_sel got=%b want=100", ALU_SELECT);
    else n_pass++;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({ALU_SELECT, DEST_REG, WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL} !== '0)
      $display("FAIL mid_reset_outputs got=%b want=0",
               {ALU_SELECT, DEST_REG, WRITE_EN, JUMP, BRANCH_TAKEN, ILLEGAL});
    else n_pass++;
    cur = '{default: 0};
    cur_dest = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if ({WRITE_EN, INSTR_READY} !== 2'b01)
        $display("FAIL post_reset cyc=%0d got we/ready=%b want=01", c, {WRITE_EN, INSTR_READY});
      else n_pass++;
      @(negedge CLK);
    end
  endtask

  task automatic test_add();
    int w;
    do_instr(32'h02030102, 0, w);
  endtask

  task automatic test_mult();
    int w;
    do_instr(32'h09010203, 0, w);
  endtask

  task automatic test_shift();
    int w;
    do_instr(32'h0A020103, 0, w);
    do_instr(32'h0B020103, 0, w);
    do_instr(32'h0C050104, 1, w);
    do_instr(32'h0D060107, 0, w);
  endtask

  task automatic test_branch();
    int w;
    do_instr(32'h07000102, 1, w);
    do_instr(32'h07000102, 0, w);
    do_instr(32'h08000102, 1, w);
    do_instr(32'h08000102, 0, w);
    do_instr(32'h06000000, 1, w);
  endtask

  task automatic test_illegal();
    int w;
    do_instr(32'h03040506, 0, w);
    do_instr(32'hFF070000, 0, w);
    do_instr(32'h00010000, 0, w);
    n_checks++;
    if (w !== 0) $display("FAIL illegal_next_accept got wait=%0d want=0", w);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] seq [6] = '{32'h02010000, 32'h09020000, 32'h0A030000, 32'h0E040000,
                             32'h05050000, 32'h08060000};
    do_instr(32'h01000000, 0, w);
    foreach (seq[i]) begin
      do_instr(seq[i], 2, w);
      n_checks++;
      if (w !== 0) $display("FAIL back_to_back idx=%0d got wait=%0d want=0", i, w);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int w;
    logic [31:0] instr;
    for (int i = 0; i < 40; i++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[31:24] = 8'($urandom_range(0, 15));
      do_instr(instr, 2, w);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_shift();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mult();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
